// File: rtl/node_sampler_if.sv
// node_sampler_if
// Result port of the node sampler: one window result per valid/ready
// handshake.
//   out_valid  - result register holds an unaccepted result
//   out_ready  - consumer accepts when out_valid && out_ready
//   out_node   - node index of the held result
//   out_count  - saturating transition count for that window
//   out_level  - synchronised level on the last cycle of the window
// Modports: master (the sampler drives the result), slave (the consumer).
interface node_sampler_if #(
    parameter int NODE_W = 4,
    parameter int CNT_W  = 4
);
    logic              out_valid;
    logic              out_ready;
    logic [NODE_W-1:0] out_node;
    logic [CNT_W-1:0]  out_count;
    logic              out_level;

    modport master (
        output out_valid,
        output out_node,
        output out_count,
        output out_level,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_node,
        input  out_count,
        input  out_level,
        output out_ready
    );
endinterface

// File: rtl/node_sampler.sv
// node_sampler
// Read-out stage for the single-node reservoir. It synchronises the
// free-running delay-loop output and splits one acquisition into N_NODES
// windows of NODE_CYCLES clocks. For each window it reports the saturating
// transition count and the final level through a one-entry result register.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - single-cycle acquisition request (ignored while busy)
//   delay_in   - asynchronous delay-chain output
//   result     - valid/ready result port (node_sampler_if.master)
//   busy       - acquisition running or result pending
//   overrun    - sticky: a window result was dropped
module node_sampler #(
    parameter int N_NODES     = 16,
    parameter int NODE_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           delay_in,
    node_sampler_if.master result,
    output logic           busy,
    output logic           overrun
);
    localparam int NODE_W = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam int WC_W   = (NODE_CYCLES > 1) ? $clog2(NODE_CYCLES) : 1;
    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(N_NODES - 1);
    localparam logic [WC_W-1:0]   LAST_WC   = WC_W'(NODE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SAMPLE
    } state_t;

    state_t            state;
    logic              s1;
    logic              s2;
    logic              prev;
    logic              edge_det;
    logic              take;
    logic [NODE_W-1:0] node;
    logic [WC_W-1:0]   wc;
    logic [CNT_W-1:0]  acc;

    // Increment that sticks at the all-ones count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             inc);
        if (inc && (value != {CNT_W{1'b1}})) begin
            return value + CNT_W'(1);
        end
        return value;
    endfunction

    assign edge_det = s2 ^ prev;
    // A window result can load when the register is empty or is being
    // emptied by a handshake in this same cycle.
    assign take     = !result.out_valid || result.out_ready;
    assign busy     = (state == SAMPLE) || result.out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1               <= 1'b0;
            s2               <= 1'b0;
            prev             <= 1'b0;
            state            <= IDLE;
            node             <= '0;
            wc               <= '0;
            acc              <= '0;
            overrun          <= 1'b0;
            result.out_valid <= 1'b0;
            result.out_node  <= '0;
            result.out_count <= '0;
            result.out_level <= 1'b0;
        end else begin
            s1   <= delay_in;
            s2   <= s1;
            prev <= s2;

            // Handshake empties the register; a reload below overrides this.
            if (result.out_valid && result.out_ready) begin
                result.out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start && !result.out_valid) begin
                        state   <= SAMPLE;
                        node    <= '0;
                        wc      <= '0;
                        acc     <= '0;
                        overrun <= 1'b0;
                    end
                end
                SAMPLE: begin
                    if (wc == LAST_WC) begin
                        // An edge on the final cycle still belongs to this window.
                        if (take) begin
                            result.out_valid <= 1'b1;
                            result.out_node  <= node;
                            result.out_count <= sat_inc(acc, edge_det);
                            result.out_level <= s2;
                        end else begin
                            overrun <= 1'b1;
                        end
                        wc  <= '0;
                        acc <= '0;
                        if (node == LAST_NODE) begin
                            state <= IDLE;
                        end else begin
                            node <= node + NODE_W'(1);
                        end
                    end else begin
                        wc  <= wc + WC_W'(1);
                        acc <= sat_inc(acc, edge_det);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/node_sampler.md
# node_sampler

Clocked read-out stage for the single-node reservoir. It takes the free-running output of the inverter delay loop, synchronises it, and splits one loop period into N_NODES virtual-node windows. For each window it reports the transition count and final level through a valid/ready port, which feeds the readout/training logic. It is the consuming end of the delay chain.

## Interface
- N_NODES, 16: virtual nodes per acquisition (≥2)
- NODE_CYCLES, 8: clock cycles per node window (≥2)
- CNT_W, 4: transition-counter width; counts saturate at 2^CNT_W−1
- clk  in  1  sole clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin one acquisition of N_NODES windows
- delay_in  in  1  asynchronous output of the delay chain
- out_valid  out  1  result register holds an unaccepted result
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_node  out  clog2(N_NODES)  index of the node for the held result
- out_count  out  CNT_W  transitions seen in that window, saturating
- out_level  out  1  synchronised level at the last cycle of the window
- busy  out  1  acquisition in progress or result pending
- overrun  out  1  sticky flag: a window result was dropped

## Operation
- Input path: 2-FF synchroniser (s1, s2), then prev register; edge = s2 ^ prev. All three reset to 0.
- FSM states:
  - IDLE: wait for start.
  - SAMPLE: run windows.
- IDLE→SAMPLE on start. Entering SAMPLE clears node index, window counter wc, count accumulator and overrun.
- start is ignored while busy=1.
- SAMPLE behaviour:
  - wc counts 0..NODE_CYCLES−1.
  - Each cycle with edge=1 increments the accumulator, saturating.
  - On the cycle with wc=NODE_CYCLES−1, the window result is {node, acc+edge (saturated), s2}.
  - If the result register is empty, or is being accepted that same cycle, the result loads and out_valid=1 next cycle.
  - Otherwise the result is dropped and overrun is set. The held result is unchanged.
  - In either case acc and wc clear and node increments.
  - After node N_NODES−1 finishes, SAMPLE→IDLE.
- Result register: one entry. out_valid clears on handshake unless it is reloaded in the same cycle.
- busy = (state==SAMPLE) || out_valid.
- overrun holds until the next accepted start or reset.
- Reset mid-acquisition: immediate return to IDLE. All outputs go to 0 and no partial result is produced.

## Timing
- Reset values: out_valid=0, out_node=0, out_count=0, out_level=0, busy=0, overrun=0.
- delay_in to edge detection: 3 cycles (s1, s2, prev).
- start high in cycle T: SAMPLE starts at T+1 and busy=1 at T+1.
- Window k covers cycles T+1+k·NODE_CYCLES through T+(k+1)·NODE_CYCLES.
- Window k result: out_valid=1 in cycle T+(k+1)·NODE_CYCLES+1.
- With out_ready held at 1, one result is delivered every NODE_CYCLES cycles.
- busy falls on the cycle after the last result is accepted.
- An edge in the last cycle of a window counts toward that window.
- Saturation: once acc = 2^CNT_W−1, further edges are ignored.

## Test plan
- delay_in=0, out_ready=1, start → 16 results, out_node 0..15, out_count=0, out_level=0, overrun=0. busy high from start+1 until the last handshake.
- delay_in toggling synchronously every clk, out_ready=1 → every out_count=8 (NODE_CYCLES=8); overrun=0.
- NODE_CYCLES=32, CNT_W=4, same toggling → every out_count=15 (saturated).
- out_ready=0 throughout the acquisition:
  - node 0 result is held with out_valid=1;
  - overrun=1 from the cycle after window 1 ends;
  - after out_ready=1, exactly one result (node 0) is delivered, then busy=0.
- Assert rst_n=0 during window 5 → all outputs 0 immediately. A new start after release yields nodes 0..15 starting from node 0.
- start pulsed again mid-acquisition → ignored; node sequence and count unaffected. A start after busy=0 clears overrun.
